// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_reg_hs elastic delay line.
// Consumers import pipe_pkg::* for the stage record and the count-width helper.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // One pipeline slot: valid flag plus payload (default-width form).
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_rec_t;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One slot of the handshake pipeline: a WIDTH-bit data register plus valid bit.
// Loads from its predecessor whenever it is empty or its successor can take its word.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             next_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_ready;

  // An empty slot never blocks, which is what collapses bubbles.
  assign w_ready = ~r_valid | next_ready;

  // NOTE: state is updated with <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      // NOTE: data is cleared on reset too, so out_data reads 0 rather than X afterwards.
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_ready) begin
      r_valid <= prev_valid;
      if (prev_valid) r_data <= prev_data;
    end
  end

  assign ready = w_ready;
  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/pipe_reg_hs.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count.
// Stage 0 is the input end; stage DEPTH-1 drives the output.
module pipe_reg_hs
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_valid;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Each generate block owns its own ready/valid/data nets so the ready chain is
  // a plain series of distinct signals rather than one self-referencing vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_ready;
    logic             w_valid;
    logic [WIDTH-1:0] w_data;
    logic             w_prev_valid;
    logic [WIDTH-1:0] w_prev_data;
    logic             w_next_ready;

    if (g == 0) begin : g_head
      assign w_prev_valid = w_in_fire;
      assign w_prev_data  = in_data;
    end else begin : g_body
      assign w_prev_valid = g_stage[g-1].w_valid;
      assign w_prev_data  = g_stage[g-1].w_data;
    end

    if (g == DEPTH - 1) begin : g_tail
      assign w_next_ready = out_ready;
    end else begin : g_link
      assign w_next_ready = g_stage[g+1].w_ready;
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .prev_valid (w_prev_valid),
      .prev_data  (w_prev_data),
      .next_ready (w_next_ready),
      .ready      (w_ready),
      .valid      (w_valid),
      .data       (w_data)
    );
  end

  assign w_in_ready  = rst_n & ~flush & g_stage[0].w_ready;
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_valid = rst_n & ~flush & g_stage[DEPTH-1].w_valid;
  assign w_out_fire  = w_out_valid & out_ready;

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_count_nxt = r_count;
    case ({w_in_fire, w_out_fire})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     r_count <= '0;
    else if (flush) r_count <= '0;
    else            r_count <= w_count_nxt;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = g_stage[DEPTH-1].w_data;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs (WIDTH=8, DEPTH=4): reset, streaming, backpressure,
// bubble collapse, full push/pop and flush, each with hand-computed per-cycle tables.
module tb_pipe_reg_hs;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // One clock cycle: inputs applied (fl, iv, id, ordy) and the outputs expected
  // in that cycle before the next rising edge (ir, ov, od when ov, cnt).
  typedef struct packed {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [2:0] cnt;
  } row_t;

  pipe_reg_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset out_data: got %h want 00", out_data); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset count: got %0d want 0", count); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release in_ready: got %b want 1", in_ready); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_release count: got %0d want 0", count); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    row_t tbl [8] = '{
      '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0},
      '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 3'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0}
    };
    foreach (tbl[k]) begin
      flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      n_cmp++; if (in_ready !== tbl[k].ir) begin n_bad++; $display("FAIL stream in_ready row %0d: got %b want %b", k, in_ready, tbl[k].ir); end
      n_cmp++; if (out_valid !== tbl[k].ov) begin n_bad++; $display("FAIL stream out_valid row %0d: got %b want %b", k, out_valid, tbl[k].ov); end
      if (tbl[k].ov) begin
        n_cmp++; if (out_data !== tbl[k].od) begin n_bad++; $display("FAIL stream out_data row %0d: got %h want %h", k, out_data, tbl[k].od); end
      end
      n_cmp++; if (count !== tbl[k].cnt) begin n_bad++; $display("FAIL stream count row %0d: got %0d want %0d", k, count, tbl[k].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    row_t tbl [12] = '{
      '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0},
      '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2},
      '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3},
      '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd4},
      '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd4},
      '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd4},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd4},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0}
    };
    foreach (tbl[k]) begin
      flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      n_cmp++; if (in_ready !== tbl[k].ir) begin n_bad++; $display("FAIL backpressure in_ready row %0d: got %b want %b", k, in_ready, tbl[k].ir); end
      n_cmp++; if (out_valid !== tbl[k].ov) begin n_bad++; $display("FAIL backpressure out_valid row %0d: got %b want %b", k, out_valid, tbl[k].ov); end
      if (tbl[k].ov) begin
        n_cmp++; if (out_data !== tbl[k].od) begin n_bad++; $display("FAIL backpressure out_data row %0d: got %h want %h", k, out_data, tbl[k].od); end
      end
      n_cmp++; if (count !== tbl[k].cnt) begin n_bad++; $display("FAIL backpressure count row %0d: got %0d want %0d", k, count, tbl[k].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubble_collapse();
    row_t tbl [6] = '{
      '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1}
    };
    foreach (tbl[k]) begin
      flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      n_cmp++; if (in_ready !== tbl[k].ir) begin n_bad++; $display("FAIL bubble in_ready row %0d: got %b want %b", k, in_ready, tbl[k].ir); end
      n_cmp++; if (out_valid !== tbl[k].ov) begin n_bad++; $display("FAIL bubble out_valid row %0d: got %b want %b", k, out_valid, tbl[k].ov); end
      if (tbl[k].ov) begin
        n_cmp++; if (out_data !== tbl[k].od) begin n_bad++; $display("FAIL bubble out_data row %0d: got %h want %h", k, out_data, tbl[k].od); end
      end
      n_cmp++; if (count !== tbl[k].cnt) begin n_bad++; $display("FAIL bubble count row %0d: got %0d want %0d", k, count, tbl[k].cnt); end
      @(posedge clk); #1;
    end
  endtask

  // Starts with 0x5A parked in the last stage; fills to 4, then 6 cycles of push+pop.
  task automatic test_full_push_pop();
    row_t tbl [9] = '{
      '{1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1},
      '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd2},
      '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd3},
      '{1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b1, 8'h5A, 3'd4},
      '{1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 8'hB0, 3'd4},
      '{1'b0, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b1, 8'hB1, 3'd4},
      '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hB2, 3'd4},
      '{1'b0, 1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 8'hC0, 3'd4},
      '{1'b0, 1'b1, 8'hC5, 1'b1, 1'b1, 1'b1, 8'hC1, 3'd4}
    };
    foreach (tbl[k]) begin
      flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      n_cmp++; if (in_ready !== tbl[k].ir) begin n_bad++; $display("FAIL full_pp in_ready row %0d: got %b want %b", k, in_ready, tbl[k].ir); end
      n_cmp++; if (out_valid !== tbl[k].ov) begin n_bad++; $display("FAIL full_pp out_valid row %0d: got %b want %b", k, out_valid, tbl[k].ov); end
      if (tbl[k].ov) begin
        n_cmp++; if (out_data !== tbl[k].od) begin n_bad++; $display("FAIL full_pp out_data row %0d: got %h want %h", k, out_data, tbl[k].od); end
      end
      n_cmp++; if (count !== tbl[k].cnt) begin n_bad++; $display("FAIL full_pp count row %0d: got %0d want %0d", k, count, tbl[k].cnt); end
      @(posedge clk); #1;
    end
  endtask

  // Pipe holds C2..C5; one pop leaves 3, then flush while offering 0xEE, then push 0x77.
  task automatic test_flush();
    row_t tbl [8] = '{
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC2, 3'd4},
      '{1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3},
      '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 3'd1},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0}
    };
    foreach (tbl[k]) begin
      flush = tbl[k].fl; in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
      @(negedge clk);
      n_cmp++; if (in_ready !== tbl[k].ir) begin n_bad++; $display("FAIL flush in_ready row %0d: got %b want %b", k, in_ready, tbl[k].ir); end
      n_cmp++; if (out_valid !== tbl[k].ov) begin n_bad++; $display("FAIL flush out_valid row %0d: got %b want %b", k, out_valid, tbl[k].ov); end
      if (tbl[k].ov) begin
        n_cmp++; if (out_data !== tbl[k].od) begin n_bad++; $display("FAIL flush out_data row %0d: got %h want %h", k, out_data, tbl[k].od); end
      end
      n_cmp++; if (count !== tbl[k].cnt) begin n_bad++; $display("FAIL flush count row %0d: got %0d want %0d", k, count, tbl[k].cnt); end
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_full_push_pop();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
